// File: rtl/gf_sq_scale_if.sv
// Operand/result handshake bundle for the GF(2^WIDTH) square-and-scale sequencer.
// The master drives operands and takes results; the slave is the sequencer.
interface gf_sq_scale_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] p;
    logic             busy;

    modport master (
        output in_valid, mode, a, b, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, mode, a, b, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/gf_sq_scale_seq.sv
// Bit-serial GF(2^WIDTH) multiplier sequenced into one or two passes to compute
// a^2*V, a*b, a^2 or a^2*b, one multiplier bit per clock.
//
// state | meaning
// IDLE  | waiting for an operand, in_ready high
// PASS1 | first multiply: a*a (modes 0,2,3) or a*b (mode 1)
// PASS2 | second multiply: a^2*V (mode 0) or a^2*b (mode 3)
// DONE  | result held on p with out_valid until out_ready
module gf_sq_scale_seq #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(4'b0011),
    parameter logic [WIDTH-1:0] V     = WIDTH'(4'd13)
) (
    input  logic          clk,
    input  logic          rst_n,
    gf_sq_scale_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, DONE} state_t;

    state_t           state;
    logic [1:0]       mode_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] acc;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] p_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [WIDTH-1:0] acc_step;

    function automatic logic [WIDTH-1:0] xtime(input logic [WIDTH-1:0] v);
        xtime = {v[WIDTH-2:0], 1'b0} ^ (v[WIDTH-1] ? POLY : '0);
    endfunction

    always_comb begin
        acc_step = y[cnt] ? (acc ^ x) : acc;
    end

    // in_ready is a pure decode of IDLE, gated so it reads 0 while reset is held
    assign bus.in_ready  = (state == IDLE) && rst_n;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.busy      = busy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mode_q      <= '0;
            b_q         <= '0;
            x           <= '0;
            y           <= '0;
            acc         <= '0;
            cnt         <= '0;
            p_q         <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mode_q <= bus.mode;
                        b_q    <= bus.b;
                        x      <= bus.a;
                        y      <= (bus.mode == 2'd1) ? bus.b : bus.a;
                        acc    <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= PASS1;
                    end
                end
                PASS1: begin
                    acc <= acc_step;
                    x   <= xtime(x);
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        if (mode_q == 2'd1 || mode_q == 2'd2) begin
                            p_q         <= acc_step;
                            out_valid_q <= 1'b1;
                            state       <= DONE;
                        end else begin
                            // the square becomes the multiplicand of the second pass
                            x     <= acc_step;
                            acc   <= '0;
                            cnt   <= '0;
                            y     <= (mode_q == 2'd0) ? V : b_q;
                            state <= PASS2;
                        end
                    end
                end
                PASS2: begin
                    acc <= acc_step;
                    x   <= xtime(x);
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        p_q         <= acc_step;
                        out_valid_q <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        p_q         <= '0;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gf_sq_scale_seq.sv
// Self-checking bench for gf_sq_scale_seq: transaction-level reference model,
// per-cycle output compare, directed literal cases and randomized traffic.
module tb_gf_sq_scale_seq;
    localparam int W = 4;
    localparam int FULL_POLY = 'h13;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;

    gf_sq_scale_if #(.WIDTH(W)) ifc ();

    gf_sq_scale_seq #(.WIDTH(W), .POLY(4'b0011), .V(4'd13)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    always #5 clk = ~clk;

    function automatic int gf_mul(input int u, input int v);
        int prod = 0;
        for (int i = 0; i < W; i++)
            if ((v >> i) & 1) prod = prod ^ (u << i);
        for (int i = 2 * W - 2; i >= W; i--)
            if ((prod >> i) & 1) prod = prod ^ (FULL_POLY << (i - W));
        return prod;
    endfunction

    function automatic int ref_result(input int m, input int u, input int v);
        int sq = gf_mul(u, u);
        case (m)
            0:       return gf_mul(sq, 13);
            1:       return gf_mul(u, v);
            2:       return sq;
            default: return gf_mul(sq, v);
        endcase
    endfunction

    function automatic int ref_latency(input int m);
        return (m == 1 || m == 2) ? W : 2 * W;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // transaction-level model: idle -> counting down the latency -> holding result
    bit m_busy = 0;
    bit m_valid = 0;
    int m_left = 0;
    int m_p = 0;
    int m_pending = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_valid = 0; m_left = 0; m_p = 0;
        end else if (m_valid) begin
            if (ifc.out_ready) begin
                m_valid = 0; m_busy = 0;
            end
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1; m_p = m_pending;
            end
        end else if (ifc.in_valid) begin
            m_busy = 1;
            m_left = ref_latency(int'(ifc.mode));
            m_pending = ref_result(int'(ifc.mode), int'(ifc.a), int'(ifc.b));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", int'(ifc.out_valid), int'(m_valid));
            chk("p", int'(ifc.p), m_valid ? m_p : 0);
            chk("busy", int'(ifc.busy), int'(m_busy));
            chk("in_ready", int'(ifc.in_ready), int'(!m_busy));
        end
    end

    task automatic scramble();
        ifc.in_valid = 1'($urandom_range(0, 1));
        ifc.mode = 2'($urandom_range(0, 3));
        ifc.a = 4'($urandom_range(0, 15));
        ifc.b = 4'($urandom_range(0, 15));
    endtask

    task automatic start_op(input int m, input int u, input int v);
        @(posedge clk); #1;
        ifc.in_valid = 1'b1;
        ifc.mode = 2'(m);
        ifc.a = 4'(u);
        ifc.b = 4'(v);
        @(posedge clk); #1;
        scramble();
    endtask

    task automatic finish_op(input int stall, output int got, output int lat);
        lat = 0;
        while (!ifc.out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            scramble();
        end
        if (!ifc.out_valid) chk("result_timeout", 0, 1);
        got = int'(ifc.p);
        repeat (stall) begin
            @(posedge clk); #1;
            scramble();
        end
        ifc.in_valid = 1'b0;
        ifc.out_ready = 1'b1;
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
    endtask

    task automatic directed(input string name, input int m, input int u, input int v,
                            input int exp_p, input int exp_lat, input int stall);
        int got, lat;
        start_op(m, u, v);
        finish_op(stall, got, lat);
        chk({name, "_p"}, got, exp_p);
        chk({name, "_lat"}, lat, exp_lat);
        chk({name, "_idle_after"}, int'(ifc.out_valid), 0);
    endtask

    initial begin
        int got, lat;
        ifc.in_valid = 1'b0; ifc.mode = 2'd0; ifc.a = '0; ifc.b = '0; ifc.out_ready = 1'b0;
        #1;
        chk("rst_out_valid", int'(ifc.out_valid), 0);
        chk("rst_p", int'(ifc.p), 0);
        chk("rst_busy", int'(ifc.busy), 0);
        chk("rst_in_ready", int'(ifc.in_ready), 0);
        #20; rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", int'(ifc.in_ready), 1);

        // pin the reference model against hand-derived values
        chk("model_m1_3_7", ref_result(1, 3, 7), 9);
        chk("model_m0_2", ref_result(0, 2, 0), 1);
        chk("model_m1_15_15", ref_result(1, 15, 15), 10);
        chk("model_m3_2_2", ref_result(3, 2, 2), 8);

        directed("m0_a2", 0, 2, 0, 1, 8, 0);
        directed("m0_a0", 0, 0, 5, 0, 8, 0);
        directed("m1_3_7", 1, 3, 7, 9, 4, 0);
        directed("m1_15_15", 1, 15, 15, 10, 4, 1);
        directed("m2_a3", 2, 3, 0, 5, 4, 0);
        directed("m3_2_2", 3, 2, 2, 8, 8, 0);
        directed("m1_b0", 1, 9, 0, 0, 4, 0);
        directed("m1_stall10", 1, 3, 7, 9, 4, 10);

        // reset during PASS2 of mode 0, then accept on the first edge after release
        start_op(0, 2, 0);
        repeat (6) @(posedge clk);
        #2; rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(ifc.out_valid), 0);
        chk("midrst_p", int'(ifc.p), 0);
        chk("midrst_busy", int'(ifc.busy), 0);
        chk("midrst_in_ready", int'(ifc.in_ready), 0);
        ifc.in_valid = 1'b1; ifc.mode = 2'd1; ifc.a = 4'd3; ifc.b = 4'd7;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        ifc.in_valid = 1'b0;
        finish_op(0, got, lat);
        chk("after_rst_p", got, 9);
        chk("after_rst_lat", lat, 4);

        for (int u = 0; u < 16; u++)
            for (int v = 0; v < 16; v++) begin
                start_op(1, u, v);
                finish_op(0, got, lat);
            end
        for (int m = 0; m < 4; m++) begin
            if (m == 1) continue;
            for (int u = 0; u < 16; u++) begin
                start_op(m, u, $urandom_range(0, 15));
                finish_op(0, got, lat);
            end
        end

        for (int n = 0; n < 60; n++) begin
            start_op($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 15));
            finish_op($urandom_range(0, 3), got, lat);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
